// File: rtl/seg_alu_scan.sv
// Captures an N-bit ALU result (add/sub/or/xor) with carry/borrow flag on load,
// and scans it as hex digits onto a multiplexed 7-segment display with registered outputs.
module seg_alu_scan #(
    parameter int N        = 8,
    parameter int PRESCALE = 4,
    localparam int DIGITS  = (N + 3) / 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      A,
    input  logic [N-1:0]      B,
    input  logic [1:0]        OP2,
    input  logic              load,
    input  logic              EN,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              dp
);

    localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PADW = DIGITS * 4;

    logic [N-1:0]        r_result;
    logic                r_flag;
    logic [PW-1:0]       r_pc;
    logic [DW-1:0]       r_di;

    logic [N:0]          w_sum;
    logic [N:0]          w_diff;
    logic [N-1:0]        w_alu;
    logic                w_alu_flag;
    logic [PADW-1:0]     w_pad;
    logic [3:0]          w_nib;
    logic [DIGITS-1:0]   w_onehot;
    logic [6:0]          w_seg;
    logic                w_last_pc;
    logic                w_last_di;

    // One extra bit captures carry-out on add and the unsigned borrow on subtract.
    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        w_alu      = '0;
        w_alu_flag = 1'b0;
        case (OP2)
            2'b00:   begin w_alu = w_sum[N-1:0];  w_alu_flag = w_sum[N];  end
            2'b10:   begin w_alu = w_diff[N-1:0]; w_alu_flag = w_diff[N]; end
            2'b01:   w_alu = A | B;
            default: w_alu = A ^ B;
        endcase
    end

    always_comb begin
        w_pad          = '0;
        w_pad[N-1:0]   = r_result;
        w_nib          = '0;
        w_onehot       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_di == DW'(i)) begin
                w_nib       = w_pad[4*i +: 4];
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_seg = 7'b0000000;
        case (w_nib)
            4'h0: w_seg = 7'b1111110;
            4'h1: w_seg = 7'b0110000;
            4'h2: w_seg = 7'b1101101;
            4'h3: w_seg = 7'b1111001;
            4'h4: w_seg = 7'b0110011;
            4'h5: w_seg = 7'b1011011;
            4'h6: w_seg = 7'b1011111;
            4'h7: w_seg = 7'b1110000;
            4'h8: w_seg = 7'b1111111;
            4'h9: w_seg = 7'b1111011;
            4'hA: w_seg = 7'b1110111;
            4'hB: w_seg = 7'b0011111;
            4'hC: w_seg = 7'b1001110;
            4'hD: w_seg = 7'b0111101;
            4'hE: w_seg = 7'b1001111;
            default: w_seg = 7'b1000111;
        endcase
    end

    assign w_last_pc = (r_pc == PW'(PRESCALE - 1));
    assign w_last_di = (r_di == DW'(DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_flag   <= 1'b0;
            r_pc     <= '0;
            r_di     <= '0;
            seg      <= '0;
            an       <= '0;
            dp       <= 1'b0;
        end else begin
            if (load) begin
                r_result <= w_alu;
                r_flag   <= w_alu_flag;
            end
            if (w_last_pc) begin
                r_pc <= '0;
                r_di <= w_last_di ? '0 : r_di + 1'b1;
            end else begin
                r_pc <= r_pc + 1'b1;
            end
            // Outputs sample pre-edge state, so a load lands on the display one edge later.
            if (EN) begin
                seg <= w_seg;
                an  <= w_onehot;
                dp  <= r_flag & w_last_di;
            end else begin
                seg <= '0;
                an  <= '0;
                dp  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_alu_scan.sv
// Directed checks of seg_alu_scan (N=8,PRESCALE=4) plus a modelled random run (N=6,PRESCALE=1).
module tb_seg_alu_scan;

    logic       clk = 1'b0;
    logic       rst1, rst2;
    logic [7:0] a1, b1;
    logic [1:0] op1;
    logic       load1, en1;
    logic [6:0] seg1;
    logic [1:0] an1;
    logic       dp1;
    logic [5:0] a2, b2;
    logic [1:0] op2;
    logic       load2, en2;
    logic [6:0] seg2;
    logic [1:0] an2;
    logic       dp2;

    int total = 0;
    int bad   = 0;
    int cyc1;

    logic [6:0] dec [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    seg_alu_scan #(.N(8), .PRESCALE(4)) dut1 (
        .clk(clk), .rst(rst1), .A(a1), .B(b1), .OP2(op1), .load(load1), .EN(en1),
        .seg(seg1), .an(an1), .dp(dp1));

    seg_alu_scan #(.N(6), .PRESCALE(1)) dut2 (
        .clk(clk), .rst(rst2), .A(a2), .B(b2), .OP2(op2), .load(load2), .EN(en2),
        .seg(seg2), .an(an2), .dp(dp2));

    always #5 clk = ~clk;

    // Edges since reset release on dut1; locates the scan position independently.
    always @(posedge clk or posedge rst1) begin
        if (rst1) cyc1 <= 0;
        else      cyc1 <= cyc1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input string tag, input int res, input bit flag, input bit en);
        int di;
        int nib;
        logic [9:0] exp;
        di  = ((cyc1 - 1) / 4) % 2;
        nib = (di == 0) ? (res % 16) : ((res / 16) % 16);
        exp = en ? {dec[nib], (di == 0) ? 2'b01 : 2'b10, (di == 1) && flag} : 10'd0;
        chk(tag, {22'd0, seg1, an1, dp1}, {22'd0, exp});
    endtask

    task automatic run(input string tag, input int n, input int res, input bit flag);
        for (int i = 0; i < n; i++) begin
            tick();
            disp(tag, res, flag, en1);
        end
    endtask

    task automatic do_load(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                           input int old_res, input bit old_flag);
        a1 = a; b1 = b; op1 = op; load1 = 1'b1;
        tick();
        load1 = 1'b0;
        disp("load_edge_old", old_res, old_flag, en1);
    endtask

    initial begin
        int m_res, m_flag, m_di, s, nib;
        logic [9:0] exp2;

        rst1 = 1'b1; rst2 = 1'b1;
        a1 = '0; b1 = '0; op1 = '0; load1 = 1'b0; en1 = 1'b1;
        a2 = '0; b2 = '0; op2 = '0; load2 = 1'b0; en2 = 1'b1;
        #2;
        chk("reset_outputs", {22'd0, seg1, an1, dp1}, 32'd0);

        // Reset release and first frame on a zero result
        tick();
        rst1 = 1'b0;
        run("rst_scan", 8, 0, 0);

        // 3C + 05 = 41, no carry
        do_load(8'h3C, 8'h05, 2'b00, 0, 0);
        run("add_nocarry", 8, 'h41, 0);

        // 05 - 06 = FF with borrow
        do_load(8'h05, 8'h06, 2'b10, 'h41, 0);
        run("sub_borrow", 8, 'hFF, 1);

        // F0 + 20 = 110: result 10, carry set
        do_load(8'hF0, 8'h20, 2'b00, 'hFF, 1);
        run("add_carry", 6, 'h10, 1);
        en1 = 1'b0;
        run("blank", 3, 'h10, 1);
        en1 = 1'b1;
        run("unblank", 6, 'h10, 1);

        // OR, then XOR
        do_load(8'h12, 8'h34, 2'b01, 'h10, 1);
        run("or", 4, 'h36, 0);
        do_load(8'hA5, 8'h0F, 2'b11, 'h36, 0);
        run("xor", 5, 'hAA, 0);

        // Load coinciding with a digit advance
        while ((cyc1 + 1) % 4 != 0) run("align", 1, 'hAA, 0);
        do_load(8'h9C, 8'h00, 2'b01, 'hAA, 0);
        run("load_on_adv", 5, 'h9C, 0);

        // Mid-scan asynchronous reset
        rst1 = 1'b1;
        #1;
        chk("async_reset", {22'd0, seg1, an1, dp1}, 32'd0);
        tick();
        rst1 = 1'b0;
        run("post_reset", 6, 0, 0);

        // N=6, PRESCALE=1: modelled vectors, starting with a zero-padded 3F
        tick();
        rst2 = 1'b0;
        m_res = 0; m_flag = 0; m_di = 0;
        for (int k = 0; k < 201; k++) begin
            if (k == 0) begin
                a2 = 6'h3F; b2 = 6'h00; op2 = 2'b01; load2 = 1'b1; en2 = 1'b1;
            end else if (k < 4) begin
                load2 = 1'b0; en2 = 1'b1;
            end else begin
                a2 = 6'($urandom_range(63)); b2 = 6'($urandom_range(63));
                op2 = 2'($urandom_range(3)); load2 = 1'($urandom_range(1));
                en2 = ($urandom_range(3) != 0);
            end
            nib  = (m_di == 0) ? (m_res % 16) : (m_res / 16);
            exp2 = en2 ? {dec[nib], (m_di == 0) ? 2'b01 : 2'b10, (m_di == 1) && (m_flag != 0)} : 10'd0;
            tick();
            chk(k < 4 ? "n6_pad" : "n6_rand", {22'd0, seg2, an2, dp2}, {22'd0, exp2});
            if (load2) begin
                case (op2)
                    2'b00: begin s = int'(a2) + int'(b2); m_res = s % 64; m_flag = (s >= 64); end
                    2'b10: begin m_res = (int'(a2) - int'(b2) + 64) % 64; m_flag = (a2 < b2); end
                    2'b01: begin m_res = int'(a2 | b2); m_flag = 0; end
                    default: begin m_res = int'(a2 ^ b2); m_flag = 0; end
                endcase
            end
            m_di = 1 - m_di;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
